key_debounce: RTL and testbench
===============================

# key_debounce

Upstream input stage for the tone-sequence game controller. It synchronises the four raw push-button lines, debounces each one independently, and turns each new press into a clean one-hot pulse on `k` for the controller's key inputs. One pulse is issued per press. Further presses are locked out until every button has been released.

## Interface
- `NUM_KEY`, 4: number of button lines; fixed at 4 in this design.
- `DEB_CYCLES`, 4: consecutive stable synchronised samples needed to accept a level change; legal range ≥1.
- `PULSE_LEN`, 2: cycles that `k` is held high per accepted press; legal range ≥1.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset reset, synchronous, active-high; clock clock.
- `btn`  in  4  raw, asynchronous, bouncing button levels; 1 = pressed.
- `k`  out  4  one-hot key pulse to the game controller.
- `key_valid`  out  1  single-cycle strobe marking the first cycle of each `k` pulse.
- `key_code`  out  2  index of the last accepted key; held until the next press.
- `multi_press`  out  1  1 if more than one debounced key was down when the last press was accepted; held with `key_code`.

## Operation
- **Synchroniser:** two flops per line, `btn` → `sync1` → `sync2`. Both reset to 0.
- **Debounce, per key i:**
  - State is `stable[i]` plus a counter of width `$clog2(DEB_CYCLES+1)`, both reset to 0.
  - If `sync2[i] == stable[i]`, the counter is cleared.
  - Otherwise, if the counter equals `DEB_CYCLES-1`, then `stable[i]` takes `sync2[i]` and the counter is cleared.
  - Otherwise the counter increments.
  - A glitch shorter than `DEB_CYCLES` samples never changes `stable`.
- **Output FSM states:** IDLE, PRESS, HOLD. Reset state is IDLE.
  - **IDLE:** if `stable != 0`:
    - Select the lowest-index set bit j.
    - Load `k` with the one-hot of j, `key_code` with j, and `key_valid` with 1.
    - Load `multi_press` with 1 if popcount(`stable`) > 1.
    - Load the pulse counter (width `$clog2(PULSE_LEN+1)`) with `PULSE_LEN-1`.
    - Go to PRESS.
    - Otherwise stay in IDLE with `k` = 0.
  - **PRESS:** `key_valid` is cleared.
    - If the pulse counter is 0, `k` is cleared and the FSM goes to HOLD.
    - Otherwise the counter decrements and `k` is held.
  - **HOLD:** `k` = 0. Go to IDLE when `stable == 0`, otherwise stay.
- **Boundary behaviour:**
  - A release during PRESS does not shorten the pulse. HOLD then sees `stable == 0` and returns to IDLE on the next edge.
  - A second key pressed during PRESS or HOLD is ignored. It is only accepted if it is still held when the FSM re-enters IDLE.
  - Lockout ends only when all keys are debounced-released together.
  - Key priority follows the controller's ordering: lowest index wins.

## Timing
- **Reset values:** `k` = 0, `key_valid` = 0, `key_code` = 0, `multi_press` = 0, FSM in IDLE, all synchroniser and debounce state cleared.
- **Reset mid-operation:** takes effect at the next edge and clears an in-flight pulse. A button held through reset is re-debounced and produces a fresh pulse after the full latency.
- **Press latency:** a `btn` rise set up before edge 1 lands in `sync2` at edge 2 and sets `stable` at edge 2+`DEB_CYCLES`. `k`/`key_valid` are registered at edge 3+`DEB_CYCLES`.
- **Pulse width:** `k` is high for exactly `PULSE_LEN` cycles. `key_valid` is high for exactly 1 cycle.
- **Release latency:** `stable` clears at edge 2+`DEB_CYCLES` after the raw fall.
- **Minimum press-to-press spacing:** `PULSE_LEN` + 1 HOLD cycle + 1 IDLE cycle after the debounced release.
- **Outputs:** all registered; no combinational path from `btn` to any output.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `PULSE_LEN`=2.
1. Reset, then `btn`=0001 before edge 1 and held → `k`=0001 after edge 7 and edge 8, 0 after edge 9; `key_valid`=1 only after edge 7; `key_code`=0, `multi_press`=0.
2. `btn[2]` toggling every 2 cycles for 20 cycles, then 0 → `k` stays 0000, `key_valid` never asserts.
3. `btn`=0110 applied simultaneously → `k`=0010, `key_code`=1, `multi_press`=1; no pulse on bit 2 until both keys are released and bit 2 is pressed again.
4. `btn`=1000 held for 100 cycles → exactly one 2-cycle pulse `k`=1000, `key_code`=3; release then re-press → a second pulse after the full latency.
5. `reset` asserted during PRESS → `k`=0 and `key_valid`=0 at the next edge. With `btn` still held after reset deasserts, a new pulse appears 7 edges later.
6. Press key 0, release at the first `k` cycle, press key 1 two cycles later → key 0 pulse is full width; key 1 pulse follows with `key_code`=1, no overlap on `k`.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button front end: per-key two-flop synchroniser and debouncer, then a
// small FSM that emits one fixed-width one-hot pulse per press with lockout.

module key_debounce_lane #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic stable
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // cnt tracks consecutive samples disagreeing with stable; any agreeing
   // sample restarts the run, so short glitches never reach the limit.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

module key_debounce #(
   parameter int NUM_KEY    = 4,
   parameter int DEB_CYCLES = 4,
   parameter int PULSE_LEN  = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_KEY-1:0]         btn,
   output logic [NUM_KEY-1:0]         k,
   output logic                       key_valid,
   output logic [$clog2(NUM_KEY)-1:0] key_code,
   output logic                       multi_press
);

   localparam int KW = $clog2(NUM_KEY);
   localparam int PW = $clog2(PULSE_LEN + 1);

   typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

   logic [NUM_KEY-1:0] stable;

   for (genvar g = 0; g < NUM_KEY; g++) begin : g_lane
      key_debounce_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
         .clock  (clock),
         .reset  (reset),
         .btn    (btn[g]),
         .stable (stable[g])
      );
   end

   state_t             state, state_nxt;
   logic [PW-1:0]      pcnt, pcnt_nxt;
   logic [NUM_KEY-1:0] k_nxt;
   logic               valid_nxt;
   logic [KW-1:0]      code_nxt;
   logic               multi_nxt;

   logic [KW-1:0]      low_idx;
   logic               many;

   // Lowest index wins: scan downwards so the last hit is the smallest.
   always_comb begin
      low_idx = '0;
      for (int i = NUM_KEY - 1; i >= 0; i--) begin
         if (stable[i]) low_idx = KW'(i);
      end
      many = |(stable & (stable - NUM_KEY'(1)));
   end

   always_comb begin
      state_nxt = state;
      pcnt_nxt  = pcnt;
      k_nxt     = k;
      valid_nxt = 1'b0;
      code_nxt  = key_code;
      multi_nxt = multi_press;
      unique case (state)
         IDLE: begin
            k_nxt = '0;
            if (|stable) begin
               k_nxt     = NUM_KEY'(1) << low_idx;
               code_nxt  = low_idx;
               valid_nxt = 1'b1;
               multi_nxt = many;
               pcnt_nxt  = PW'(PULSE_LEN - 1);
               state_nxt = PRESS;
            end
         end
         PRESS: begin
            if (pcnt == '0) begin
               k_nxt     = '0;
               state_nxt = HOLD;
            end else begin
               pcnt_nxt = pcnt - PW'(1);
            end
         end
         HOLD: begin
            k_nxt = '0;
            if (stable == '0) state_nxt = IDLE;
         end
         default: begin
            k_nxt     = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         pcnt        <= '0;
         k           <= '0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         multi_press <= 1'b0;
      end else begin
         state       <= state_nxt;
         pcnt        <= pcnt_nxt;
         k           <= k_nxt;
         key_valid   <= valid_nxt;
         key_code    <= code_nxt;
         multi_press <= multi_nxt;
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random button traffic, all
// compared cycle by cycle against a sliding-window / pulse-budget model.

module tb_key_debounce;

   localparam int DEB = 4;
   localparam int PL  = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn   = 4'b0000;
   logic [3:0] k;
   logic       key_valid;
   logic [1:0] key_code;
   logic       multi_press;

   int checks = 0;
   int errors = 0;

   key_debounce #(.NUM_KEY(4), .DEB_CYCLES(DEB), .PULSE_LEN(PL)) dut (
      .clock       (clock),
      .reset       (reset),
      .btn         (btn),
      .k           (k),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .multi_press (multi_press)
   );

   always #5 clock = ~clock;

   // Reference: a key's debounced level flips once the last DEB synchronised
   // samples all show the opposite level; the output side is a pulse budget
   // plus a lock that opens only when no key is debounced-down.
   logic [3:0]     m_s1, m_s2, m_stab, n_s1, n_s2, n_stab;
   logic [DEB-1:0] m_hist [4];
   logic [DEB-1:0] n_hist [4];
   int             m_rem, n_rem;
   logic           m_lock, n_lock;
   logic [3:0]     m_k, n_k;
   logic           m_valid, n_valid;
   logic [1:0]     m_code, n_code;
   logic           m_multi, n_multi;

   always_comb begin
      n_s1    = btn;
      n_s2    = m_s1;
      n_stab  = m_stab;
      n_hist  = m_hist;
      n_rem   = m_rem;
      n_lock  = m_lock;
      n_k     = m_k;
      n_valid = 1'b0;
      n_code  = m_code;
      n_multi = m_multi;
      for (int i = 0; i < 4; i++) begin
         n_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
         if (!m_stab[i] && (&n_hist[i])) n_stab[i] = 1'b1;
         else if (m_stab[i] && !(|n_hist[i])) n_stab[i] = 1'b0;
      end
      if (m_rem > 0) begin
         n_rem = m_rem - 1;
         if (n_rem == 0) n_k = 4'b0000;
      end else if (m_lock) begin
         if (m_stab == 4'b0000) n_lock = 1'b0;
      end else if (m_stab != 4'b0000) begin
         n_k = m_stab & (~m_stab + 4'd1);
         for (int j = 0; j < 4; j++) if (n_k[j]) n_code = 2'(j);
         n_multi = ($countones(m_stab) > 1);
         n_valid = 1'b1;
         n_rem   = PL;
         n_lock  = 1'b1;
      end
   end

   always @(posedge clock) begin
      if (reset) begin
         m_s1 <= '0; m_s2 <= '0; m_stab <= '0;
         m_hist <= '{default: '0};
         m_rem <= 0; m_lock <= 1'b0; m_k <= '0;
         m_valid <= 1'b0; m_code <= '0; m_multi <= 1'b0;
      end else begin
         m_s1 <= n_s1; m_s2 <= n_s2; m_stab <= n_stab; m_hist <= n_hist;
         m_rem <= n_rem; m_lock <= n_lock; m_k <= n_k;
         m_valid <= n_valid; m_code <= n_code; m_multi <= n_multi;
      end
   end

   task automatic tick(input logic [3:0] b);
      btn = b;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(4'b0000);
      tick(4'b0000);
      checks++;
      if ({k, key_valid, key_code, multi_press} !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: got k=%b v=%b code=%0d multi=%b, want all 0", k, key_valid, key_code, multi_press);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_press();
      logic [3:0] ek;
      reset = 1'b1;
      tick(4'b0000);
      reset = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         tick(4'b0001);
         ek = (n == 7 || n == 8) ? 4'b0001 : 4'b0000;
         checks++;
         if (k !== ek || key_valid !== (n == 7)) begin
            errors++;
            $display("FAIL single_edge%0d: got k=%b v=%b, want k=%b v=%b", n, k, key_valid, ek, (n == 7));
         end
         if (n == 7) begin
            checks++;
            if (key_code !== 2'd0 || multi_press !== 1'b0) begin
               errors++;
               $display("FAIL single_code: got code=%0d multi=%b, want 0 0", key_code, multi_press);
            end
         end
      end
      for (int n = 0; n < 12; n++) begin
         tick(4'b0000);
         checks++;
         if ({k, key_valid, key_code, multi_press} !== {m_k, m_valid, m_code, m_multi}) begin
            errors++;
            $display("FAIL single_release: got k=%b v=%b code=%0d multi=%b, want k=%b v=%b code=%0d multi=%b",
                     k, key_valid, key_code, multi_press, m_k, m_valid, m_code, m_multi);
         end
      end
   endtask

   task automatic test_glitch();
      for (int c = 0; c < 32; c++) begin
         tick((c < 20 && ((c / 2) % 2 == 1)) ? 4'b0100 : 4'b0000);
         checks++;
         if (k !== 4'b0000 || key_valid !== 1'b0 || k !== m_k) begin
            errors++;
            $display("FAIL glitch_c%0d: got k=%b v=%b, want k=0000 v=0", c, k, key_valid);
         end
      end
   endtask

   task automatic test_multi();
      int hits1, hits2;
      hits1 = 0; hits2 = 0;
      for (int c = 0; c < 72; c++) begin
         tick(c < 20 ? 4'b0110 : c < 40 ? 4'b0100 : c < 52 ? 4'b0000 : 4'b0100);
         if (k == 4'b0010) hits1++;
         if (k[2]) begin
            hits2++;
            checks++;
            if (c < 52) begin
               errors++;
               $display("FAIL multi_lockout: got k=%b at c%0d, want no bit 2 before full release", k, c);
            end
         end
         if (key_valid) begin
            checks++;
            if (c < 20 ? (k !== 4'b0010 || key_code !== 2'd1 || multi_press !== 1'b1)
                       : (k !== 4'b0100 || key_code !== 2'd2 || multi_press !== 1'b0)) begin
               errors++;
               $display("FAIL multi_accept c%0d: got k=%b code=%0d multi=%b", c, k, key_code, multi_press);
            end
         end
         checks++;
         if ({k, key_valid, key_code, multi_press} !== {m_k, m_valid, m_code, m_multi}) begin
            errors++;
            $display("FAIL multi_model c%0d: got k=%b v=%b code=%0d multi=%b, want k=%b v=%b code=%0d multi=%b",
                     c, k, key_valid, key_code, multi_press, m_k, m_valid, m_code, m_multi);
         end
      end
      checks++;
      if (hits1 !== 2 || hits2 !== 2) begin
         errors++;
         $display("FAIL multi_widths: got key1 %0d key2 %0d cycles, want 2 and 2", hits1, hits2);
      end
      for (int c = 0; c < 12; c++) tick(4'b0000);
   endtask

   task automatic test_long_hold();
      int hi, vc, first;
      for (int r = 0; r < 2; r++) begin
         hi = 0; vc = 0; first = 0;
         for (int n = 1; n <= 100; n++) begin
            tick(4'b1000);
            if (k == 4'b1000) begin
               hi++;
               if (first == 0) first = n;
            end
            if (key_valid) vc++;
         end
         checks++;
         if (hi !== PL || vc !== 1 || first !== 7 || key_code !== 2'd3) begin
            errors++;
            $display("FAIL long_hold r%0d: got %0d high, %0d strobes, first edge %0d, code %0d; want 2,1,7,3",
                     r, hi, vc, first, key_code);
         end
         for (int c = 0; c < 12; c++) tick(4'b0000);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick(4'b0001);
         if (k != 4'b0000) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rstmid_timeout: got no pulse in 20 cycles, want a pulse");
      end
      reset = 1'b1;
      tick(4'b0001);
      checks++;
      if (k !== 4'b0000 || key_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_clear: got k=%b v=%b, want 0000 0", k, key_valid);
      end
      reset = 1'b0;
      n = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick(4'b0001);
         n++;
         if (k != 4'b0000) seen = 1'b1;
         checks++;
         if ({k, key_valid, key_code, multi_press} !== {m_k, m_valid, m_code, m_multi}) begin
            errors++;
            $display("FAIL rstmid_model: got k=%b v=%b, want k=%b v=%b", k, key_valid, m_k, m_valid);
         end
      end
      checks++;
      if (!seen || n !== 7) begin
         errors++;
         $display("FAIL rstmid_latency: got pulse after %0d edges (seen=%0d), want 7", n, seen);
      end
      for (int c = 0; c < 14; c++) tick(4'b0000);
   endtask

   task automatic test_back_to_back();
      int hi0, hi1, vc;
      bit seen;
      logic [3:0] b;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick(4'b0001);
         if (k != 4'b0000) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL b2b_timeout: got no key0 pulse in 20 cycles, want a pulse");
      end
      hi0 = (k == 4'b0001) ? 1 : 0;
      hi1 = 0; vc = 0;
      for (int c = 0; c < 30; c++) begin
         b = (c < 2) ? 4'b0000 : 4'b0010;
         tick(b);
         if (k == 4'b0001) hi0++;
         if (k == 4'b0010) hi1++;
         if (key_valid) begin
            vc++;
            checks++;
            if (key_code !== 2'd1 || multi_press !== 1'b0) begin
               errors++;
               $display("FAIL b2b_code: got code=%0d multi=%b, want 1 0", key_code, multi_press);
            end
         end
         checks++;
         if ($countones(k) > 1 || {k, key_valid, key_code} !== {m_k, m_valid, m_code}) begin
            errors++;
            $display("FAIL b2b_model c%0d: got k=%b v=%b code=%0d, want k=%b v=%b code=%0d",
                     c, k, key_valid, key_code, m_k, m_valid, m_code);
         end
      end
      checks++;
      if (hi0 !== PL || hi1 !== PL || vc !== 1) begin
         errors++;
         $display("FAIL b2b_widths: got key0 %0d key1 %0d strobes %0d, want 2 2 1", hi0, hi1, vc);
      end
      for (int c = 0; c < 12; c++) tick(4'b0000);
   endtask

   task automatic test_random();
      int cyc, len;
      logic [3:0] b;
      cyc = 0;
      while (cyc < 800) begin
         case ($urandom_range(0, 5))
            0:       b = 4'b0000;
            5:       b = 4'($urandom_range(0, 15));
            default: b = 4'b0001 << $urandom_range(0, 3);
         endcase
         len = $urandom_range(1, 12);
         for (int c = 0; c < len; c++) begin
            tick(b);
            cyc++;
            checks++;
            if ({k, key_valid, key_code, multi_press} !== {m_k, m_valid, m_code, m_multi}) begin
               errors++;
               $display("FAIL random c%0d: got k=%b v=%b code=%0d multi=%b, want k=%b v=%b code=%0d multi=%b",
                        cyc, k, key_valid, key_code, multi_press, m_k, m_valid, m_code, m_multi);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_multi();
      test_long_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
